// File: rtl/l4_mac_window_ctrl.sv
// l4_mac_window_ctrl
//   Sequences operand beats for the registered L4 MAC into windows of ACC_LEN
//   beats, drives the MAC's accum_en, captures z when each window's result
//   has settled, and queues {z, window tag} in a small FIFO for downstream.
// Ports
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready operand beat handshake with the upstream streamer
//   op_zero           upstream must zero a/w this cycle (no beat accepted)
//   accum_en          to MAC: 0 = load product, 1 = add product
//   z                 MAC result
//   out_valid/ready   result FIFO head handshake
//   out_data/out_tag  captured window result and its window index
//   busy              partial window open, capture in flight or FIFO non-empty
//   ovf_err           sticky capture-while-full indicator
module l4_mac_window_ctrl #(
  parameter int Z_WIDTH    = 32,
  parameter int ACC_LEN    = 16,
  parameter int MAC_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int RST_HOLD   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               op_zero,
  output logic               accum_en,
  input  logic [Z_WIDTH-1:0] z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Z_WIDTH-1:0] out_data,
  output logic [15:0]        out_tag,
  output logic               busy,
  output logic               ovf_err
);

  localparam int CNT_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PEND_W = $clog2(MAC_LAT + 1);
  localparam int CRED_W = $clog2(FIFO_DEPTH + MAC_LAT + 1);

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(ACC_LEN - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);
  localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [MAC_LAT-1:0]  pipe_q, pipe_d;
  logic [15:0]         tag_q, tag_d;
  logic [Z_WIDTH-1:0]  mem_data_q [FIFO_DEPTH];
  logic [Z_WIDTH-1:0]  mem_data_d [FIFO_DEPTH];
  logic [15:0]         mem_tag_q  [FIFO_DEPTH];
  logic [15:0]         mem_tag_d  [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FCNT_W-1:0]   count_q, count_d;
  logic                ovf_q, ovf_d;

  logic [PEND_W-1:0]   pending_s;
  logic [CRED_W-1:0]   credit_s;
  logic                last_slot_s;
  logic                run_s;
  logic                beat_s;
  logic                capture_s;
  logic                pop_s;
  logic                push_ok_s;

  // Handshake, MAC control and FIFO head outputs.
  always_comb begin
    pending_s = '0;
    for (int i = 0; i < MAC_LAT; i++) begin
      pending_s = pending_s + PEND_W'(pipe_q[i]);
    end
    // Results already queued plus results still travelling through the MAC.
    credit_s    = CRED_W'(count_q) + CRED_W'(pending_s);
    last_slot_s = (beat_cnt_q == LAST_CNT);
    run_s       = !rst && (state_q == ST_RUN);

    // Only a window-closing beat needs a FIFO slot reserved for its result.
    if (run_s) begin
      if (last_slot_s && (credit_s >= CRED_MAX)) begin
        in_ready = 1'b0;
      end else begin
        in_ready = 1'b1;
      end
    end else begin
      in_ready = 1'b0;
    end

    beat_s  = in_valid & in_ready;
    op_zero = !beat_s;

    // Bubbles add a zero product so the running sum is preserved.
    if (run_s) begin
      if (beat_s) begin
        accum_en = (beat_cnt_q != '0);
      end else begin
        accum_en = 1'b1;
      end
    end else begin
      accum_en = 1'b0;
    end

    capture_s = pipe_q[MAC_LAT-1];
    out_valid = !rst && (count_q != '0);
    pop_s     = out_valid & out_ready;
    // A pop in the same cycle makes room even when the FIFO is full.
    push_ok_s = capture_s & ((count_q != FULL_CNT) | pop_s);
    out_data  = mem_data_q[rd_ptr_q];
    out_tag   = mem_tag_q[rd_ptr_q];
    busy      = (beat_cnt_q != '0) | (pending_s != '0) | (count_q != '0);
    ovf_err   = ovf_q & !rst;
  end

  // Next-state logic for the hold FSM, window counter, capture pipe and FIFO.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    beat_cnt_d = beat_cnt_q;
    pipe_d     = '0;
    tag_d      = tag_q;
    mem_data_d = mem_data_q;
    mem_tag_d  = mem_tag_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;

    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
    endcase

    if (beat_s) begin
      if (last_slot_s) begin
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end else begin
      beat_cnt_d = beat_cnt_q;
    end

    // A last-beat flag leaves the pipe exactly when z holds that window's sum.
    pipe_d[0] = beat_s & last_slot_s;
    for (int i = 1; i < MAC_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    if (capture_s) begin
      tag_d = tag_q + 16'd1;
    end else begin
      tag_d = tag_q;
    end

    if (push_ok_s) begin
      mem_data_d[wr_ptr_q] = z;
      mem_tag_d[wr_ptr_q]  = tag_q;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase

    if (capture_s && !push_ok_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      beat_cnt_q <= '0;
      pipe_q     <= '0;
      tag_q      <= '0;
      mem_data_q <= '{default: '0};
      mem_tag_q  <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      pipe_q     <= pipe_d;
      tag_q      <= tag_d;
      mem_data_q <= mem_data_d;
      mem_tag_q  <= mem_tag_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_l4_mac_window_ctrl.sv
// Testbench for l4_mac_window_ctrl.
//   dut_a: ACC_LEN=4, FIFO_DEPTH=4 -- directed windows, throttling, reset, random traffic.
//   dut_b: ACC_LEN=1 -- 65537 single-beat windows to wrap the 16-bit tag.
//   Each DUT drives a behavioural MAC (input register + accumulator register).
//   Expected results come from a window-level model: every ACC_LEN accepted
//   beats sum to one result, visible MAC_LAT+1 cycles after the last beat.
module tb_l4_mac_window_ctrl;

  localparam int ACC   = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int HOLD  = 2;
  localparam int NB    = 65537;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid_a, in_ready_a, op_zero_a, accum_en_a;
  logic        out_valid_a, out_ready_a, busy_a, ovf_err_a;
  logic [31:0] z_a, out_data_a, val_a;
  logic [15:0] out_tag_a;
  logic        in_valid_b, in_ready_b, op_zero_b, accum_en_b;
  logic        out_valid_b, out_ready_b, busy_b, ovf_err_b;
  logic [31:0] z_b, out_data_b, val_b;
  logic [15:0] out_tag_b;

  l4_mac_window_ctrl #(.Z_WIDTH(32), .ACC_LEN(ACC), .MAC_LAT(LAT), .FIFO_DEPTH(DEPTH), .RST_HOLD(HOLD)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .op_zero(op_zero_a),
    .accum_en(accum_en_a), .z(z_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_tag(out_tag_a), .busy(busy_a), .ovf_err(ovf_err_a));

  l4_mac_window_ctrl #(.Z_WIDTH(32), .ACC_LEN(1), .MAC_LAT(LAT), .FIFO_DEPTH(DEPTH), .RST_HOLD(HOLD)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .op_zero(op_zero_b),
    .accum_en(accum_en_b), .z(z_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_tag(out_tag_b), .busy(busy_b), .ovf_err(ovf_err_b));

  // Behavioural MACs: product registered with accum_en, then accumulated.
  logic [31:0] mac_a_p, mac_a_acc, mac_b_p, mac_b_acc;
  logic        mac_a_en, mac_b_en;
  always @(posedge clk) begin
    if (rst) begin
      mac_a_p <= 32'd0; mac_a_en <= 1'b0; mac_a_acc <= 32'd0;
      mac_b_p <= 32'd0; mac_b_en <= 1'b0; mac_b_acc <= 32'd0;
    end else begin
      mac_a_p   <= op_zero_a ? 32'd0 : val_a;
      mac_a_en  <= accum_en_a;
      mac_a_acc <= mac_a_en ? (mac_a_acc + mac_a_p) : mac_a_p;
      mac_b_p   <= op_zero_b ? 32'd0 : val_b;
      mac_b_en  <= accum_en_b;
      mac_b_acc <= mac_b_en ? (mac_b_acc + mac_b_p) : mac_b_p;
    end
  end
  assign z_a = mac_a_acc;
  assign z_b = mac_b_acc;

  int checks = 0;
  int errors = 0;

  task automatic chk32(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic chk1(input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", name, obs, exp);
    end
  endtask

  // Window-level reference model for dut_a.
  typedef struct {
    logic [31:0] sum;
    logic [15:0] tag;
    int          vis;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] pop_log[$];
  logic [15:0] pop_tag_log[$];
  int          win_pos   = 0;
  logic [31:0] win_sum   = 32'd0;
  logic [15:0] m_tag     = 16'd0;
  int          since_rst = 0;
  int          cyc       = 0;
  bit          last_beat = 1'b0;

  // One clock of dut_a: check at negedge, advance model at posedge.
  task automatic cycle();
    bit   run, ir, bt, ov, ae;
    exp_t e;
    @(negedge clk);
    run = !rst && (since_rst >= HOLD);
    ir  = run && !((win_pos == ACC - 1) && (exp_q.size() >= DEPTH));
    bt  = in_valid_a && ir;
    ov  = !rst && (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
    ae  = !run ? 1'b0 : (bt ? (win_pos != 0) : 1'b1);
    chk1("in_ready", in_ready_a, ir);
    chk1("op_zero", op_zero_a, !bt);
    chk1("accum_en", accum_en_a, ae);
    chk1("out_valid", out_valid_a, ov);
    chk1("ovf_err", ovf_err_a, 1'b0);
    if (ov) begin
      chk32("out_data", out_data_a, exp_q[0].sum);
      chk32("out_tag", {16'd0, out_tag_a}, {16'd0, exp_q[0].tag});
    end
    if (!rst) begin
      chk1("busy", busy_a, (win_pos != 0) || (exp_q.size() != 0));
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      win_pos = 0; win_sum = 32'd0; m_tag = 16'd0; since_rst = 0;
    end else begin
      if (since_rst < HOLD) since_rst++;
      if (ov && out_ready_a) begin
        pop_log.push_back(exp_q[0].sum);
        pop_tag_log.push_back(exp_q[0].tag);
        void'(exp_q.pop_front());
      end
      if (bt) begin
        win_sum = win_sum + val_a;
        if (win_pos == ACC - 1) begin
          e.sum = win_sum; e.tag = m_tag; e.vis = cyc + LAT + 1;
          exp_q.push_back(e);
          m_tag   = m_tag + 16'd1;
          win_pos = 0;
          win_sum = 32'd0;
        end else begin
          win_pos++;
        end
      end
    end
    last_beat = bt;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    in_valid_a = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic offer(input logic [31:0] v);
    in_valid_a = 1'b1;
    val_a      = v;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (last_beat) break;
    end
    chk1("offer_accepted", last_beat, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid_a = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    pop_log.delete();
    pop_tag_log.delete();
  endtask

  initial begin
    int          nb_acc, nb_pop;
    logic [31:0] qb[$];
    logic [31:0] bexp;
    logic [15:0] tag_b, last_tag_b;
    bit          acc_b;

    rst = 1'b1;
    in_valid_a = 1'b0; out_ready_a = 1'b0; val_a = 32'd0;
    in_valid_b = 1'b0; out_ready_b = 1'b0; val_b = 32'd0;

    // Reset values, then two back-to-back windows of 1..8.
    do_reset();
    out_ready_a = 1'b1;
    for (int k = 1; k <= 8; k++) offer(32'(k));
    idle(6);
    chk32("t1_count", 32'(pop_log.size()), 32'd2);
    chk32("t1_sum0", pop_log[0], 32'd10);
    chk32("t1_sum1", pop_log[1], 32'd26);
    chk32("t1_tag1", {16'd0, pop_tag_log[1]}, 32'd1);

    // Three-cycle bubble inside a window.
    do_reset();
    offer(32'd1); offer(32'd2);
    idle(3);
    offer(32'd3); offer(32'd4);
    idle(6);
    chk32("t2_sum", pop_log[0], 32'd10);
    chk32("t2_tag", {16'd0, pop_tag_log[0]}, 32'd0);

    // Stalled downstream: 5th window's last beat is held back, then drain.
    do_reset();
    out_ready_a = 1'b0;
    for (int k = 0; k < 19; k++) offer($urandom);
    in_valid_a = 1'b1;
    val_a = $urandom;
    repeat (4) cycle();
    chk1("t3_throttled", in_ready_a, 1'b0);
    out_ready_a = 1'b1;
    for (int k = 0; k < 5; k++) offer((k == 0) ? val_a : $urandom);
    idle(12);
    chk32("t3_count", 32'(pop_tag_log.size()), 32'd6);
    for (int k = 0; k < 6; k++) chk32("t3_tag_order", {16'd0, pop_tag_log[k]}, 32'(k));

    // Reset in the middle of a window with a result already queued.
    do_reset();
    out_ready_a = 1'b0;
    for (int k = 0; k < 6; k++) offer(32'd1000 + 32'(k));
    idle(3);
    chk1("t4_valid_before", out_valid_a, 1'b1);
    do_reset();
    out_ready_a = 1'b1;
    for (int k = 1; k <= 4; k++) offer(32'(k));
    idle(6);
    chk32("t4_count", 32'(pop_log.size()), 32'd1);
    chk32("t4_sum", pop_log[0], 32'd10);
    chk32("t4_tag", {16'd0, pop_tag_log[0]}, 32'd0);

    // Random traffic with back-pressure and one mid-run reset.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      rst         = (i == 250);
      in_valid_a  = ($urandom_range(0, 3) != 0);
      val_a       = $urandom;
      out_ready_a = ($urandom_range(0, 2) != 0);
      cycle();
    end
    out_ready_a = 1'b1;
    idle(20);
    chk1("rand_drained", out_valid_a, 1'b0);

    // ACC_LEN=1 instance: every beat is a window, tag wraps past 0xFFFF.
    nb_acc = 0; nb_pop = 0; tag_b = 16'd0; last_tag_b = 16'hFFFF;
    in_valid_b = 1'b1; out_ready_b = 1'b1; val_b = 32'h0000_1234;
    for (int c = 0; c < 70000 && nb_pop < NB; c++) begin
      @(negedge clk);
      acc_b = in_valid_b && in_ready_b;
      if (acc_b) begin
        chk1("b_accum_en", accum_en_b, 1'b0);
        qb.push_back(val_b);
        nb_acc++;
      end
      if (out_valid_b && out_ready_b) begin
        bexp = (qb.size() > 0) ? qb.pop_front() : 32'hDEAD_BEEF;
        chk32("b_data", out_data_b, bexp);
        chk32("b_tag", {16'd0, out_tag_b}, {16'd0, tag_b});
        last_tag_b = out_tag_b;
        tag_b = tag_b + 16'd1;
        nb_pop++;
      end
      @(posedge clk);
      #1;
      if (acc_b) val_b = val_b + 32'h9E37_79B9;
      if (nb_acc >= NB) in_valid_b = 1'b0;
    end
    chk32("b_pop_count", 32'(nb_pop), 32'(NB));
    chk32("b_last_tag", {16'd0, last_tag_b}, 32'd0);
    chk1("b_ovf_err", ovf_err_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
